shift_seq_ctrl: RTL

Sequencer that sits directly upstream of the parameterised universal shift register and drives its control and data inputs. It accepts a parallel word over a valid/ready handshake and issues one parallel-load cycle. It then issues exactly N shift cycles in the requested direction, which serialises the word out of the register's s_left_dout or s_right_dout. It supports pausing mid-frame and signals completion with a one-cycle done pulse.

---
 rtl/shift_seq_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/shift_seq_ctrl.sv
// Sequencer for a universal shift register: takes a parallel word over a
// valid/ready handshake, issues one load cycle, then N shift cycles with done.
module shift_seq_ctrl #(
    parameter int N  = 4,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_valid,
    output logic          start_ready,
    input  logic [N-1:0]  din,
    input  logic          dir,
    input  logic          fill_bit,
    input  logic          pause,
    output logic [1:0]    s_out,
    output logic [N-1:0]  d_out,
    output logic          sr_din,
    output logic          sl_din,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] shift_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_LOAD  = 2'b01,
        S_SHIFT = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    localparam logic [1:0]    MODE_HOLD  = 2'b00;
    localparam logic [1:0]    MODE_RIGHT = 2'b01;
    localparam logic [1:0]    MODE_LEFT  = 2'b10;
    localparam logic [1:0]    MODE_LOAD  = 2'b11;
    localparam logic [CW-1:0] CNT_LAST   = CW'(N - 1);

    state_t       state;
    state_t       state_next;
    logic [N-1:0] word_q;
    logic         dir_q;
    logic         fill_q;
    logic         accept;
    logic         shift_step;

    assign accept     = (state == S_IDLE) && start_valid;
    assign shift_step = (state == S_SHIFT) && !pause;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: next-state and output logic assign a default first, so no path
    // through the case leaves a variable unassigned and infers a latch.
    always_comb begin
        state_next = S_IDLE;
        unique case (state)
            S_IDLE:  state_next = accept ? S_LOAD : S_IDLE;
            S_LOAD:  state_next = S_SHIFT;
            S_SHIFT: state_next = (shift_step && shift_cnt == CNT_LAST) ? S_DONE : S_SHIFT;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Capture registers are written only on the accept edge, so later changes
    // on din/dir/fill_bit cannot disturb a frame in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q    <= '0;
            dir_q     <= 1'b0;
            fill_q    <= 1'b0;
            shift_cnt <= '0;
        end else if (accept) begin
            word_q    <= din;
            dir_q     <= dir;
            fill_q    <= fill_bit;
            shift_cnt <= '0;
        end else if (shift_step) begin
            shift_cnt <= shift_cnt + CW'(1);
        end else if (state == S_DONE) begin
            shift_cnt <= '0;
        end
    end

    always_comb begin
        s_out       = MODE_HOLD;
        d_out       = '0;
        sr_din      = 1'b0;
        sl_din      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        start_ready = 1'b0;
        unique case (state)
            S_IDLE: begin
                start_ready = 1'b1;
            end
            S_LOAD: begin
                s_out = MODE_LOAD;
                d_out = word_q;
                busy  = 1'b1;
            end
            S_SHIFT: begin
                // pause is the only input allowed to reach an output directly.
                s_out  = pause ? MODE_HOLD : (dir_q ? MODE_LEFT : MODE_RIGHT);
                d_out  = word_q;
                sr_din = fill_q;
                sl_din = fill_q;
                busy   = 1'b1;
            end
            S_DONE: begin
                d_out = word_q;
                busy  = 1'b1;
                done  = 1'b1;
            end
            default: begin
                start_ready = 1'b0;
            end
        endcase
    end

endmodule
